// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus arbiter.
// The arbiter top (mem_bus_arbiter) imports this package.
package mem_bus_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2
  } arb_state_e;

  // Access size encoding, shared by d_size and BSIZE.
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  // Command latched at grant and frozen for the whole bus transaction.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [1:0]  size;
    logic [31:0] wdata;
  } bus_cmd_t;

  // Fetches are always word-sized reads with no write data.
  function automatic bus_cmd_t fetch_cmd(input logic [31:0] addr);
    bus_cmd_t c;
    c.addr  = addr;
    c.write = 1'b0;
    c.size  = SZ_WORD;
    c.wdata = 32'h0;
    return c;
  endfunction

  // Load/store command, taken verbatim from the data port.
  function automatic bus_cmd_t data_cmd(input logic [31:0] addr,
                                        input logic        write,
                                        input logic [1:0]  size,
                                        input logic [31:0] wdata);
    bus_cmd_t c;
    c.addr  = addr;
    c.write = write;
    c.size  = size;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_timeout_ctr.sv
// bus_timeout_ctr: wait-cycle counter for the memory bus arbiter.
// Counts cycles while enable_i is high and flags the cycle in which the
// count reaches TIMEOUT_CYCLES. Only instantiated when the arbiter is
// built with MEM_BUS_ARB_TIMEOUT_EN defined.
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;
  logic [TO_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  // Expired in the wait cycle whose increment lands on the limit, so the
  // abort takes effect at the end of the TIMEOUT_CYCLES-th wait cycle.
  assign expired_o = enable_i & (cnt_inc == LIMIT);

  // Next count: clear wins, saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_inc;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between the instruction
// fetch port and the load/store data port. Data has fixed priority.
// Optional build macro MEM_BUS_ARB_TIMEOUT_EN adds a wait-cycle timeout that
// aborts a transaction and pulses bus_err; without it the FSM waits forever
// for BACK_n and bus_err is constant 0.
//
// Handshake: a requester raises req with its fields and holds them until it
// sees its ready pulse (one cycle). A request is only eligible while the
// same requester's ready is low, which masks the cycle in which it is still
// dropping req. Fields are sampled once at grant; later changes are ignored.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  // data port
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  // core status
  output logic        stall,
  output logic        bus_err,
  // external memory bus
  output logic [31:0] BAD,
  output logic        BREQ,
  output logic        BWRITE,
  output logic [1:0]  BSIZE,
  output logic [31:0] BDT_o,
  output logic        BDT_oe,
  input  logic [31:0] BDT_i,
  input  logic        BACK_n
);

  arb_state_e  state_q, state_d;
  bus_cmd_t    cmd_q, cmd_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic        d_ready_q, d_ready_d;
  logic        bus_err_q, bus_err_d;

  logic        busy;
  logic        ack;
  logic        abort;
  logic        d_elig;
  logic        if_elig;

  assign busy    = (state_q != IDLE);
  // BACK_n only matters while a transaction is on the bus.
  assign ack     = busy & ~BACK_n;
  assign d_elig  = d_req & ~d_ready_q;
  assign if_elig = if_req & ~if_ready_q;

`ifdef MEM_BUS_ARB_TIMEOUT_EN
  logic to_expired;

  // Counter is held clear in IDLE, so it starts from zero at every grant.
  bus_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (~busy),
    .enable_i (busy & BACK_n),
    .expired_o(to_expired)
  );

  // An acknowledge in the same cycle as the timeout completes normally.
  assign abort = to_expired & ~ack;
`else
  logic [TO_W-1:0] unused_timeout_cfg;

  assign unused_timeout_cfg = TO_W'(TIMEOUT_CYCLES);
  assign abort              = 1'b0;
`endif

  // Next-state and datapath: arbitrate in IDLE, complete on ack or abort.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    bus_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_elig) begin
          state_d = BUS_D;
          cmd_d   = data_cmd(d_addr, d_write, d_size, d_wdata);
        end else if (if_elig) begin
          state_d = BUS_I;
          cmd_d   = fetch_cmd(if_addr);
        end
      end
      BUS_I: begin
        if (ack) begin
          state_d    = IDLE;
          if_rdata_d = BDT_i;
          if_ready_d = 1'b1;
        end else if (abort) begin
          state_d    = IDLE;
          if_rdata_d = 32'h0;
          if_ready_d = 1'b1;
          bus_err_d  = 1'b1;
        end
      end
      BUS_D: begin
        if (ack) begin
          state_d   = IDLE;
          d_rdata_d = cmd_q.write ? 32'h0 : BDT_i;
          d_ready_d = 1'b1;
        end else if (abort) begin
          state_d   = IDLE;
          d_rdata_d = 32'h0;
          d_ready_d = 1'b1;
          bus_err_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, command and response registers; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign if_rdata = if_rdata_q;
  assign if_ready = if_ready_q;
  assign d_rdata  = d_rdata_q;
  assign d_ready  = d_ready_q;
  assign bus_err  = bus_err_q;

  assign stall    = (if_req & ~if_ready_q) | (d_req & ~d_ready_q);

  assign BREQ     = busy;
  assign BAD      = cmd_q.addr;
  assign BWRITE   = busy & cmd_q.write;
  assign BSIZE    = cmd_q.size;
  assign BDT_o    = cmd_q.wdata;
  assign BDT_oe   = BREQ & BWRITE;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed + randomized bench for mem_bus_arbiter.
// The bench model is a priority-ordered queue of expected transactions:
// data before fetch, each taking (1 + waits) bus cycles and followed by a
// one-cycle ready with the acknowledged data (0 for stores).
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int TO_LIMIT = 4;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    bit          wr;
    logic [1:0]  sz;
    logic [31:0] wd;
    int          waits;
    logic [31:0] rd;
  } txn_t;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_write;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        stall;
  logic        bus_err;
  logic [31:0] BAD;
  logic        BREQ;
  logic        BWRITE;
  logic [1:0]  BSIZE;
  logic [31:0] BDT_o;
  logic        BDT_oe;
  logic [31:0] BDT_i;
  logic        BACK_n;

  int          checks;
  int          failures;
  txn_t        exp_q[$];
  logic [31:0] last_if;
  logic [31:0] last_d;

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES(TO_LIMIT),
    .TO_W          (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .if_addr (if_addr),
    .if_rdata(if_rdata),
    .if_ready(if_ready),
    .d_req   (d_req),
    .d_write (d_write),
    .d_size  (d_size),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ready (d_ready),
    .stall   (stall),
    .bus_err (bus_err),
    .BAD     (BAD),
    .BREQ    (BREQ),
    .BWRITE  (BWRITE),
    .BSIZE   (BSIZE),
    .BDT_o   (BDT_o),
    .BDT_oe  (BDT_oe),
    .BDT_i   (BDT_i),
    .BACK_n  (BACK_n)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk_txn(input bit is_d, input logic [31:0] addr, input bit wr,
                                  input logic [1:0] sz, input logic [31:0] wd,
                                  input int waits, input logic [31:0] rd);
    txn_t t;
    t.is_d  = is_d;
    t.addr  = addr;
    t.wr    = wr;
    t.sz    = sz;
    t.wd    = wd;
    t.waits = waits;
    t.rd    = rd;
    return t;
  endfunction

  // Present up to one data and one fetch request in the same cycle, act as
  // the memory for each expected transaction, and check every bus cycle.
  task automatic run_set(input bit use_d, input txn_t td, input bit use_i, input txn_t ti);
    txn_t        t;
    logic [1:0]  exp_sz;
    logic [31:0] exp_rd;
    @(negedge clk);
    exp_q.delete();
    if (use_d) begin
      d_req   = 1'b1;
      d_addr  = td.addr;
      d_write = td.wr;
      d_size  = td.sz;
      d_wdata = td.wd;
      exp_q.push_back(td);
    end
    if (use_i) begin
      if_req  = 1'b1;
      if_addr = ti.addr;
      exp_q.push_back(ti);
    end
    #1;
    chk("stall_on_req", {31'b0, stall}, {31'b0, (use_d | use_i)});
    while (exp_q.size() > 0) begin
      t      = exp_q.pop_front();
      exp_sz = t.is_d ? t.sz : SZ_WORD;
      exp_rd = (t.is_d && t.wr) ? 32'h0 : t.rd;
      for (int j = 0; j <= t.waits; j++) begin
        @(negedge clk);
        chk("bus_breq", {31'b0, BREQ}, 32'd1);
        chk("bus_bad", BAD, t.addr);
        chk("bus_bsize", {30'b0, BSIZE}, {30'b0, exp_sz});
        chk("bus_bwrite", {31'b0, BWRITE}, {31'b0, (t.is_d & t.wr)});
        chk("bus_bdt_oe", {31'b0, BDT_oe}, {31'b0, (t.is_d & t.wr)});
        if (t.is_d && t.wr) chk("bus_bdt_o", BDT_o, t.wd);
        chk("wait_no_ready", {30'b0, if_ready, d_ready}, 32'd0);
        chk("wait_stall", {31'b0, stall}, 32'd1);
        // Granted fields must be frozen: scramble the winner's inputs.
        if (t.is_d) begin
          d_addr  = $urandom;
          d_wdata = $urandom;
          d_write = 1'($urandom_range(0, 1));
          d_size  = 2'($urandom_range(0, 2));
        end else begin
          if_addr = $urandom;
        end
        BACK_n = (j == t.waits) ? 1'b0 : 1'b1;
        BDT_i  = (j == t.waits) ? t.rd : $urandom;
      end
      @(negedge clk);
      BACK_n = 1'b1;
      BDT_i  = $urandom;
      chk("rdy_breq_low", {31'b0, BREQ}, 32'd0);
      chk("rdy_bus_err", {31'b0, bus_err}, 32'd0);
      chk("rdy_stall", {31'b0, stall}, {31'b0, (exp_q.size() > 0)});
      if (t.is_d) begin
        chk("rdy_d_ready", {31'b0, d_ready}, 32'd1);
        chk("rdy_if_quiet", {31'b0, if_ready}, 32'd0);
        chk("rdy_d_rdata", d_rdata, exp_rd);
        last_d = exp_rd;
      end else begin
        chk("rdy_if_ready", {31'b0, if_ready}, 32'd1);
        chk("rdy_d_quiet", {31'b0, d_ready}, 32'd0);
        chk("rdy_if_rdata", if_rdata, exp_rd);
        last_if = exp_rd;
      end
      @(posedge clk);
      #1;
      if (t.is_d) d_req = 1'b0;
      else        if_req = 1'b0;
    end
    // Idle afterwards: no bus activity, read data held.
    repeat (2) @(negedge clk);
    chk("idle_breq", {31'b0, BREQ}, 32'd0);
    chk("hold_if_rdata", if_rdata, last_if);
    chk("hold_d_rdata", d_rdata, last_d);
  endtask

  txn_t none;

  initial begin
    checks   = 0;
    failures = 0;
    last_if  = 32'h0;
    last_d   = 32'h0;
    none     = mk_txn(1'b0, 32'h0, 1'b0, SZ_WORD, 32'h0, 0, 32'h0);
    rst      = 1'b0;
    if_req   = 1'b0;
    if_addr  = 32'h0;
    d_req    = 1'b0;
    d_write  = 1'b0;
    d_size   = SZ_WORD;
    d_addr   = 32'h0;
    d_wdata  = 32'h0;
    BDT_i    = 32'h0;
    BACK_n   = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_breq", {31'b0, BREQ}, 32'd0);
    chk("rst_bad", BAD, 32'h0);
    chk("rst_bdt_oe", {31'b0, BDT_oe}, 32'd0);
    chk("rst_readys", {30'b0, if_ready, d_ready}, 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'h0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
    rst = 1'b1;

    // BACK_n is ignored while idle.
    @(negedge clk);
    BACK_n = 1'b0;
    BDT_i  = 32'h1234_5678;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ack_breq", {31'b0, BREQ}, 32'd0);
      chk("idle_ack_ready", {30'b0, if_ready, d_ready}, 32'd0);
    end
    BACK_n = 1'b1;

    // Fetch only, zero wait.
    run_set(1'b0, none, 1'b1, mk_txn(1'b0, 32'h0001_0000, 1'b0, SZ_WORD, 32'h0, 0, 32'h0050_0093));
    // Simultaneous: byte load wins, fetch granted right after its ready.
    run_set(1'b1, mk_txn(1'b1, 32'h0000_2000, 1'b0, SZ_BYTE, 32'h0, 0, 32'hA5A5_0F0F),
            1'b1, mk_txn(1'b0, 32'h0001_0004, 1'b0, SZ_WORD, 32'h0, 0, 32'h0010_0113));
    // Half-word store with three wait states.
    run_set(1'b1, mk_txn(1'b1, 32'h0000_3002, 1'b1, SZ_HALF, 32'hDEAD_BEEF, 3, 32'h7777_7777),
            1'b0, none);

    // Reset in the middle of a store with BACK_n high.
    @(negedge clk);
    d_req   = 1'b1;
    d_write = 1'b1;
    d_addr  = 32'h0000_4000;
    d_wdata = 32'hCAFE_F00D;
    d_size  = SZ_WORD;
    @(negedge clk);
    chk("pre_rst_breq", {31'b0, BREQ}, 32'd1);
    chk("pre_rst_oe", {31'b0, BDT_oe}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_breq", {31'b0, BREQ}, 32'd0);
    chk("mid_rst_oe", {31'b0, BDT_oe}, 32'd0);
    chk("mid_rst_readys", {30'b0, if_ready, d_ready}, 32'd0);
    chk("mid_rst_bad", BAD, 32'h0);
    chk("mid_rst_bdt_o", BDT_o, 32'h0);
    chk("mid_rst_rdata", if_rdata | d_rdata, 32'h0);
    last_if = 32'h0;
    last_d  = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rearb_breq", {31'b0, BREQ}, 32'd1);
    chk("rearb_bad", BAD, 32'h0000_4000);
    BACK_n = 1'b0;
    @(negedge clk);
    BACK_n = 1'b1;
    chk("rearb_d_ready", {31'b0, d_ready}, 32'd1);
    chk("rearb_d_rdata", d_rdata, 32'h0);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    repeat (2) @(negedge clk);

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    // Fetch with no acknowledge: aborted after TO_LIMIT wait cycles.
    if_req  = 1'b1;
    if_addr = 32'h0000_8000;
    for (int j = 0; j < TO_LIMIT; j++) begin
      @(negedge clk);
      chk("to_wait_breq", {31'b0, BREQ}, 32'd1);
      chk("to_wait_ready", {31'b0, if_ready}, 32'd0);
    end
    @(negedge clk);
    chk("to_if_ready", {31'b0, if_ready}, 32'd1);
    chk("to_bus_err", {31'b0, bus_err}, 32'd1);
    chk("to_if_rdata", if_rdata, 32'h0);
    chk("to_breq_low", {31'b0, BREQ}, 32'd0);
    last_if = 32'h0;
    @(posedge clk);
    #1;
    if_req = 1'b0;
    // Acknowledge on the last wait cycle before the limit wins.
    run_set(1'b0, none, 1'b1,
            mk_txn(1'b0, 32'h0000_8004, 1'b0, SZ_WORD, 32'h0, TO_LIMIT - 1, 32'h0BAD_CAFE));
`else
    // No timeout: the bus waits as long as the memory takes.
    run_set(1'b0, none, 1'b1,
            mk_txn(1'b0, 32'h0000_8000, 1'b0, SZ_WORD, 32'h0, 40, 32'h0BAD_CAFE));
`endif

    // Randomized mixes of fetch/load/store.
    for (int k = 0; k < 12; k++) begin
      int   sel;
      txn_t rd_t;
      txn_t ri_t;
      sel  = $urandom_range(1, 3);
      rd_t = mk_txn(1'b1, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                    $urandom, $urandom_range(0, 3), $urandom);
      ri_t = mk_txn(1'b0, $urandom, 1'b0, SZ_WORD, 32'h0, $urandom_range(0, 3), $urandom);
      run_set(sel[0], rd_t, sel[1], ri_t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequential controller that shares one external memory bus between the core's instruction-fetch port and its load/store data port. Each requester gets a request/ready handshake. The block serializes transactions onto the shared bus, waits for the memory's active-low acknowledge, returns registered read data, and gives the core a stall signal while either access is outstanding. It sits between the processor datapath and the unified memory.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum bus cycles to wait for BACK_n before abort (only used with the timeout feature).
- TO_W, 8: timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetched instruction, valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for a fetch.
- d_req  in  1  data request; held until d_ready.
- d_write  in  1  1=store, 0=load.
- d_size  in  2  00 word, 01 half, 10 byte.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data, valid while d_ready=1.
- d_ready  out  1  one-cycle completion pulse for a data access.
- stall  out  1  (if_req & ~if_ready) | (d_req & ~d_ready); combinational.
- bus_err  out  1  one-cycle pulse on timeout abort.
- BAD  out  32  bus address.
- BREQ  out  1  bus request, high for the whole transaction.
- BWRITE  out  1  bus write strobe.
- BSIZE  out  2  bus size; same encoding as d_size. Fetches drive 00.
- BDT_o  out  32  bus write data.
- BDT_oe  out  1  write-data output enable (BREQ & BWRITE).
- BDT_i  in  32  bus read data.
- BACK_n  in  1  memory acknowledge, active-low.

## Operation
- FSM states: IDLE, BUS_I, BUS_D.
- IDLE:
  - A request is eligible when req=1 and the same requester's ready=0 in this cycle. This masks the cycle in which the requester is still dropping req.
  - d_req has fixed priority over if_req. When d_req is eligible, go to BUS_D.
  - Otherwise, when if_req is eligible, go to BUS_I.
  - Otherwise, stay in IDLE.
- On grant, register BAD, BWRITE, BSIZE and BDT_o from the winning requester. These values stay frozen until the transaction ends; changes to the requester inputs mid-transaction are ignored.
- BUS_I / BUS_D:
  - BREQ=1.
  - When BACK_n=0 is sampled, capture BDT_i into the rdata register of the granted side. For a store, d_rdata is 0.
  - Then pulse the matching ready for one cycle, drop BREQ, and return to IDLE.
- A pending if_req that lost arbitration stays pending and is granted from IDLE once no eligible d_req exists.
- if_rdata and d_rdata hold their last captured value between transactions.
- Address alignment is not checked. The memory owns byte-lane steering.
- Reset (asynchronous, any state, including mid-transaction):
  - FSM goes to IDLE.
  - BREQ, BWRITE, BDT_oe, if_ready, d_ready and bus_err are all 0.
  - BAD, BDT_o, BSIZE, if_rdata and d_rdata are all 0.
  - A transaction in flight is abandoned with no ready.

## Timing
- Grant edge E0: IDLE samples an eligible request. BREQ is high from E0 onward.
- Zero-wait memory: BACK_n is low in the cycle after E0, sampled at E1. ready and rdata are valid in the cycle after E1, and BREQ is low in that cycle.
- Minimum transaction is 2 cycles from grant to ready. Each wait cycle adds 1.
- Back-to-back: the earliest next grant is the edge at the end of the ready cycle. The same requester is masked for that one cycle.
- BACK_n is ignored in IDLE.

## Configuration
- Macro: MEM_BUS_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on grant and increments each BUS_I/BUS_D cycle while BACK_n=1.
  - When it reaches TIMEOUT_CYCLES, abort: pulse the granted ready with rdata=0, pulse bus_err in the same cycle, drop BREQ, and return to IDLE.
  - If BACK_n=0 and the timeout occur in the same cycle, the acknowledge wins and bus_err=0.
- Undefined: no counter. The FSM waits indefinitely, and bus_err is tied to 0.

## Structure
- Package mem_bus_pkg holds:
  - the state enum (IDLE, BUS_I, BUS_D);
  - the size constants SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10.
- Sub-module bus_timeout_ctr (clear, enable, expired output) is instantiated only under MEM_BUS_ARB_TIMEOUT_EN.

## Test plan
- Fetch only: if_req=1, if_addr=0x10000, BACK_n low one cycle after BREQ with BDT_i=0x00500093 -> BAD=0x10000, BSIZE=00; if_ready pulses 1 cycle with if_rdata=0x00500093; stall drops that cycle.
- Simultaneous: if_req and d_req (load, addr 0x2000, size 10) asserted in the same cycle -> BAD=0x2000 first and d_ready first. Then BAD=0x10004 for the fetch, starting at the edge after d_ready.
- Store with 3 wait states: d_write=1, d_wdata=0xDEADBEEF, size 01 -> BWRITE=1, BDT_oe=1, BDT_o=0xDEADBEEF, BSIZE=01 for 4 cycles; d_ready after ack; d_rdata=0.
- Reset mid-transaction: rst low while in BUS_D with BACK_n high -> BREQ, BDT_oe and both ready outputs go to 0 immediately; after release, FSM is in IDLE and re-arbitrates held requests.
- Timeout (macro defined, TIMEOUT_CYCLES=4): BACK_n held high -> after 4 wait cycles, if_ready and bus_err pulse together with if_rdata=0. Without the macro, BREQ stays high indefinitely.
- Ack/timeout collision (macro defined): BACK_n goes low on exactly the 4th wait cycle -> normal completion with captured data and bus_err=0.
